// File: rtl/ro_sweep_controller.sv
// Ring-oscillator sweep controller: selects a channel, waits a settle window, counts synchronized
// rising edges of the muxed oscillator over a gate, and returns results on a valid/ready handshake.
module ro_sweep_controller #(
  parameter int unsigned NUM_CH        = 16,
  parameter int unsigned SEL_W         = 4,
  parameter int unsigned GATE_W        = 16,
  parameter int unsigned CNT_W         = 20,
  parameter int unsigned SETTLE_CYCLES = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              cmd_go,
  input  logic              cmd_sweep,
  input  logic [SEL_W-1:0]  cmd_ch,
  input  logic [GATE_W-1:0] cmd_gate,
  input  logic              ro_in,
  output logic [SEL_W-1:0]  ro_sel,
  output logic              ro_start,
  output logic              busy,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [SEL_W-1:0]  res_ch,
  output logic [CNT_W-1:0]  res_count,
  output logic              res_ovf,
  output logic              sweep_done
);

  localparam int unsigned SetW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SetW-1:0]  SettleLoad = SetW'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntMax     = '1;
  localparam logic [SEL_W-1:0] LastCh     = SEL_W'(NUM_CH - 1);

  typedef enum logic [1:0] {StIdle, StSettle, StGate, StHold} state_e;

  state_e            state_q, state_d;
  logic              sync1_q, sync2_q, ro_prev_q;
  logic              sweep_q, sweep_d;
  logic [GATE_W-1:0] gate_q, gate_d;
  logic [SEL_W-1:0]  ch_q, ch_d;
  logic [SetW-1:0]   settle_q, settle_d;
  logic [GATE_W-1:0] gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              start_q, start_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              rise;

  assign rise = sync2_q & ~ro_prev_q;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= StIdle;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      ro_prev_q  <= 1'b0;
      sweep_q    <= 1'b0;
      gate_q     <= '0;
      ch_q       <= '0;
      settle_q   <= '0;
      gate_cnt_q <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= ro_in;
      sync2_q    <= sync1_q;
      ro_prev_q  <= sync2_q;
      sweep_q    <= sweep_d;
      gate_q     <= gate_d;
      ch_q       <= ch_d;
      settle_q   <= settle_d;
      gate_cnt_q <= gate_cnt_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sweep_d    = sweep_q;
    gate_d     = gate_q;
    ch_d       = ch_q;
    settle_d   = settle_q;
    gate_cnt_d = gate_cnt_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    start_d    = start_q;
    busy_d     = busy_q;
    valid_d    = valid_q;
    done_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_go) begin
          sweep_d  = cmd_sweep;
          gate_d   = cmd_gate;
          ch_d     = cmd_sweep ? '0 : cmd_ch;
          busy_d   = 1'b1;
          start_d  = 1'b1;
          settle_d = SettleLoad;
          state_d  = StSettle;
        end
      end
      StSettle: begin
        if (settle_q == '0) begin
          cnt_d      = '0;
          ovf_d      = 1'b0;
          // A zero gate behaves as a one-cycle gate
          gate_cnt_d = (gate_q == '0) ? '0 : gate_q - 1'b1;
          state_d    = StGate;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      StGate: begin
        if (rise) begin
          if (cnt_q == CntMax) ovf_d = 1'b1;
          else                 cnt_d = cnt_q + 1'b1;
        end
        if (gate_cnt_q == '0) begin
          valid_d = 1'b1;
          start_d = 1'b0;
          state_d = StHold;
        end else begin
          gate_cnt_d = gate_cnt_q - 1'b1;
        end
      end
      StHold: begin
        if (res_ready) begin
          valid_d = 1'b0;
          if (!sweep_q || ch_q == LastCh) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = StIdle;
          end else begin
            ch_d     = ch_q + 1'b1;
            start_d  = 1'b1;
            settle_d = SettleLoad;
            state_d  = StSettle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // ch_q only moves at command accept or HOLD exit, so it serves as both mux select and result tag
  assign ro_sel     = ch_q;
  assign res_ch     = ch_q;
  assign res_count  = cnt_q;
  assign res_ovf    = ovf_q;
  assign ro_start   = start_q;
  assign busy       = busy_q;
  assign res_valid  = valid_q;
  assign sweep_done = done_q;

endmodule

// File: tb/tb_ro_sweep_controller.sv
// Bench for ro_sweep_controller: an oscillator-bank model feeds ro_in from ro_sel, and results are
// checked against edge counts derived from each channel's period and the gate length.
module tb_ro_sweep_controller;

  logic        clk, rst;
  logic        go, sweep, ready, ro1;
  logic [3:0]  ch;
  logic [15:0] gate;
  logic [3:0]  ro_sel, res_ch;
  logic        ro_start, busy, res_valid, res_ovf, done;
  logic [19:0] res_count;

  logic        go2, sweep2, ready2, ro2;
  logic [3:0]  ch2;
  logic [15:0] gate2;
  logic [3:0]  ro_sel2, res_ch2;
  logic        ro_start2, busy2, res_valid2, res_ovf2, done2;
  logic [3:0]  res_count2;

  int errs = 0;
  int checks = 0;
  int unsigned hp1 [16];
  int unsigned hp2 [16];
  int unsigned cyc = 0;

  ro_sweep_controller dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .cmd_go(go), .cmd_sweep(sweep), .cmd_ch(ch),
    .cmd_gate(gate), .ro_in(ro1), .ro_sel(ro_sel), .ro_start(ro_start), .busy(busy),
    .res_valid(res_valid), .res_ready(ready), .res_ch(res_ch), .res_count(res_count),
    .res_ovf(res_ovf), .sweep_done(done)
  );

  ro_sweep_controller #(.CNT_W(4)) dut4 (
    .wb_clk_i(clk), .wb_rst_i(rst), .cmd_go(go2), .cmd_sweep(sweep2), .cmd_ch(ch2),
    .cmd_gate(gate2), .ro_in(ro2), .ro_sel(ro_sel2), .ro_start(ro_start2), .busy(busy2),
    .res_valid(res_valid2), .res_ready(ready2), .res_ch(res_ch2), .res_count(res_count2),
    .res_ovf(res_ovf2), .sweep_done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Oscillator bank behind the mux: channel k toggles every hp[k] cycles
  initial begin
    ro1 = 1'b0;
    ro2 = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      ro1 = ((cyc / hp1[ro_sel]) % 2) == 1;
      ro2 = ((cyc / hp2[ro_sel2]) % 2) == 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // Rising edges of a period-p square wave in a g-cycle window: within one of g/p
  function automatic bit count_ok(input int cnt, input int g, input int p);
    int diff;
    diff = cnt * p - g;
    if (diff < 0) diff = -diff;
    return diff <= p;
  endfunction

  task automatic chk_count(input string name, input int cnt, input int g, input int p);
    checks++;
    if (!count_ok(cnt, g, p)) begin
      errs++;
      $display("FAIL %s: got %0d required %0d/%0d +/-1", name, cnt, g, p);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_ro_sel"}, int'(ro_sel), 0);
    chk({tag, "_ro_start"}, int'(ro_start), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_res_valid"}, int'(res_valid), 0);
    chk({tag, "_res_ch"}, int'(res_ch), 0);
    chk({tag, "_res_count"}, int'(res_count), 0);
    chk({tag, "_res_ovf"}, int'(res_ovf), 0);
    chk({tag, "_sweep_done"}, int'(done), 0);
  endtask

  // Issue one command and check every result, the handshake and the completion pulse
  task automatic run_cmd(input bit sw, input int c, input int g, input int ready_pct,
                         input int hold_first, input bit poke, input int exp_n,
                         input int exp_first);
    int exp_ch[$];
    int geff, idx, held, first_seen;
    bit fin, stall, acc_prev;
    logic [3:0] s_ch, s_sel;
    logic [19:0] s_cnt;
    logic s_ovf;
    if (sw) for (int k = 0; k < 16; k++) exp_ch.push_back(k);
    else exp_ch.push_back(c);
    geff = (g == 0) ? 1 : g;
    idx = 0; held = 0; fin = 0; stall = 0; acc_prev = 0; first_seen = -1;
    s_ch = '0; s_sel = '0; s_cnt = '0; s_ovf = 1'b0;
    @(negedge clk);
    sweep = sw; ch = 4'(c); gate = 16'(g); go = 1'b1; ready = 1'b0;
    @(negedge clk);
    go = 1'b0;
    ch = 4'($urandom_range(15)); gate = 16'($urandom_range(500, 900)); sweep = ~sw;
    chk("busy_after_go", int'(busy), 1);
    chk("ro_start_after_go", int'(ro_start), 1);
    chk("ro_sel_after_go", int'(ro_sel), exp_ch[0]);
    for (int t = 0; t < 20000 && !fin; t++) begin
      go = 1'b0;
      if (done) begin
        chk("done_right_after_last_accept", int'(acc_prev && idx == exp_ch.size()), 1);
        chk("busy_low_with_done", int'(busy), 0);
        fin = 1;
      end else begin
        if (stall) begin
          chk("hold_valid", int'(res_valid), 1);
          chk("hold_res_ch", int'(res_ch), int'(s_ch));
          chk("hold_res_count", int'(res_count), int'(s_cnt));
          chk("hold_res_ovf", int'(res_ovf), int'(s_ovf));
          chk("hold_ro_sel", int'(ro_sel), int'(s_sel));
          chk("hold_ro_start", int'(ro_start), 0);
        end
        if (res_valid && idx == 0 && held < hold_first) begin
          ready = 1'b0;
          held++;
        end else begin
          ready = ($urandom_range(99) < ready_pct);
        end
        if (poke && t == 3) begin
          go = 1'b1; sweep = ~sw; ch = 4'(c) ^ 4'hA; gate = 16'(g + 300);
        end
        acc_prev = 0;
        if (res_valid && ready) begin
          if (idx < exp_ch.size()) begin
            if (first_seen < 0) first_seen = int'(res_ch);
            chk("res_ch_order", int'(res_ch), exp_ch[idx]);
            chk_count("res_count", int'(res_count), geff, 2 * int'(hp1[exp_ch[idx]]));
            chk("res_ovf", int'(res_ovf), 0);
            chk("ro_start_low_in_hold", int'(ro_start), 0);
            chk("busy_in_hold", int'(busy), 1);
            if (poke && idx == exp_ch.size() - 1) begin
              go = 1'b1; sweep = 1'b1; ch = 4'd0; gate = 16'd3;
            end
          end else begin
            chk("extra_result", idx, exp_ch.size() - 1);
          end
          idx++;
          acc_prev = 1;
        end
        stall = res_valid && !ready;
        s_ch = res_ch; s_cnt = res_count; s_ovf = res_ovf; s_sel = ro_sel;
        @(negedge clk);
      end
    end
    if (!fin) chk("sweep_done_within_budget", 0, 1);
    go = 1'b0;
    ready = 1'b0;
    chk("result_count", idx, exp_n);
    chk("first_result_ch", first_seen, exp_first);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("single_done_pulse", int'(done), 0);
      chk("idle_after_done", int'(busy), 0);
    end
  endtask

  typedef struct {
    bit sw;
    int ch;
    int gate;
    int ready_pct;
    int hold_first;
    bit poke;
    int exp_n;
    int exp_first;
  } vec_t;

  vec_t tbl [5];

  initial begin
    rst = 1'b1; go = 1'b0; sweep = 1'b0; ch = '0; gate = '0; ready = 1'b0;
    go2 = 1'b0; sweep2 = 1'b0; ch2 = '0; gate2 = '0; ready2 = 1'b0;
    for (int k = 0; k < 16; k++) begin
      hp1[k] = k + 2;
      hp2[k] = 32;
    end
    hp2[0] = 2;
    tbl[0] = '{sw: 1, ch: 0,  gate: 64, ready_pct: 100, hold_first: 0,  poke: 0,
               exp_n: 16, exp_first: 0};
    tbl[1] = '{sw: 1, ch: 3,  gate: 20, ready_pct: 100, hold_first: 50, poke: 0,
               exp_n: 16, exp_first: 0};
    tbl[2] = '{sw: 0, ch: 9,  gate: 0,  ready_pct: 100, hold_first: 0,  poke: 1,
               exp_n: 1, exp_first: 9};
    tbl[3] = '{sw: 0, ch: 15, gate: 37, ready_pct: 50,  hold_first: 3,  poke: 1,
               exp_n: 1, exp_first: 15};
    tbl[4] = '{sw: 1, ch: 7,  gate: 5,  ready_pct: 60,  hold_first: 0,  poke: 1,
               exp_n: 16, exp_first: 0};

    repeat (2) @(negedge clk);
    chk_zero_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single channel 5 at period 8, gate 100
    hp1[5] = 4;
    run_cmd(0, 5, 100, 100, 0, 0, 1, 5);
    hp1[5] = 7;

    for (int i = 0; i < 5; i++)
      run_cmd(tbl[i].sw, tbl[i].ch, tbl[i].gate, tbl[i].ready_pct, tbl[i].hold_first,
              tbl[i].poke, tbl[i].exp_n, tbl[i].exp_first);

    for (int i = 0; i < 8; i++) begin
      bit sw;
      int c;
      for (int k = 0; k < 16; k++) hp1[k] = $urandom_range(2, 6);
      sw = ($urandom_range(3) == 0);
      c = $urandom_range(15);
      run_cmd(sw, c, $urandom_range(0, 30), $urandom_range(30, 100), $urandom_range(0, 5),
              $urandom_range(1), sw ? 16 : 1, sw ? 0 : c);
    end

    // Saturating counter build: channel 0 overflows, channel 1 must start clean
    begin
      int n;
      int cnt0, ovf0, cnt1, ovf1;
      bit fin2;
      n = 0; fin2 = 0; cnt0 = -1; ovf0 = -1; cnt1 = -1; ovf1 = -1;
      @(negedge clk);
      sweep2 = 1'b1; ch2 = 4'd6; gate2 = 16'd100; go2 = 1'b1; ready2 = 1'b1;
      @(negedge clk);
      go2 = 1'b0;
      for (int t = 0; t < 4000 && !fin2; t++) begin
        if (done2) fin2 = 1;
        else begin
          if (res_valid2) begin
            if (n == 0) begin cnt0 = int'(res_count2); ovf0 = int'(res_ovf2); end
            if (n == 1) begin cnt1 = int'(res_count2); ovf1 = int'(res_ovf2); end
            chk("sat_build_order", int'(res_ch2), n);
            n++;
          end
          @(negedge clk);
        end
      end
      if (!fin2) chk("sat_build_done_within_budget", 0, 1);
      ready2 = 1'b0;
      chk("sat_build_results", n, 16);
      chk("sat_count", cnt0, 15);
      chk("sat_ovf", ovf0, 1);
      chk("sat_next_ovf_cleared", ovf1, 0);
      chk_count("sat_next_count", cnt1, 100, 64);
    end

    // Reset in the middle of a gate
    for (int k = 0; k < 16; k++) hp1[k] = k + 2;
    hp1[5] = 4;
    @(negedge clk);
    sweep = 1'b0; ch = 4'd5; gate = 16'd100; go = 1'b1; ready = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (30) @(negedge clk);
    chk("mid_gate_busy", int'(busy), 1);
    #2 rst = 1'b1;
    #1 chk_zero_outputs("rst_mid_gate");
    @(negedge clk);
    rst = 1'b0;
    run_cmd(0, 5, 100, 100, 0, 0, 1, 5);

    // Reset while a result is held
    @(negedge clk);
    sweep = 1'b0; ch = 4'd2; gate = 16'd10; go = 1'b1; ready = 1'b0;
    @(negedge clk);
    go = 1'b0;
    for (int t = 0; t < 100 && !res_valid; t++) @(negedge clk);
    chk("hold_reached", int'(res_valid), 1);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_zero_outputs("rst_mid_hold");
    @(negedge clk);
    rst = 1'b0;
    run_cmd(0, 5, 100, 100, 0, 0, 1, 5);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
